// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the hart's fetch and load/store units, the
// arbiter and the shared memory port. The arbiter uses the slave view.
interface mem_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ready;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;

  logic        i_ls_req;
  logic        i_ls_wen;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [3:0]  i_ls_mask;
  logic        o_ls_ready;
  logic        o_ls_valid;
  logic [31:0] o_ls_rdata;

  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  modport master (
    output i_if_req, i_if_addr, i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata,
           i_ls_mask, i_mem_ready, i_mem_valid, i_mem_rdata,
    input  o_if_ready, o_if_valid, o_if_rdata, o_ls_ready, o_ls_valid,
           o_ls_rdata, o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
  );

  modport slave (
    input  i_if_req, i_if_addr, i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata,
           i_ls_mask, i_mem_ready, i_mem_valid, i_mem_rdata,
    output o_if_ready, o_if_valid, o_if_rdata, o_ls_ready, o_ls_valid,
           o_ls_rdata, o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter for fetch and load/store with one outstanding access.
// Define MEM_ARB_RR_EN for round-robin ties instead of data priority + starve limit.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mem_arbiter_if.slave bus,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        grant_if, grant_ls, tie_to_if;
  logic [31:0] addr_q, wdata_q, if_rdata_q, ls_rdata_q;
  logic [3:0]  mask_q;
  logic        wen_q, owner_ls_q, if_valid_q, ls_valid_q;

`ifdef MEM_ARB_RR_EN
  logic last_ls_q;

  // Resetting to "data" makes fetch win the first tie.
  assign tie_to_if = last_ls_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_ls_q <= 1'b1;
    end else if (grant_if || grant_ls) begin
      last_ls_q <= grant_ls;
    end
  end
`else
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q;

  assign tie_to_if = (starve_q == LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_q <= '0;
    end else if (grant_if) begin
      starve_q <= '0;
    end else if (grant_ls && bus.i_if_req && (starve_q != LIMIT)) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`endif

  // Handshakes: a request is held until its ready pulses (only in IDLE, never
  // during reset); valid is a one-cycle registered pulse in RESP, so a
  // requester never sees ready and valid together. o_mem_req stays high with
  // stable fields until i_mem_ready; i_mem_valid counts only in WAIT.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_ls = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_rst) begin
          if (bus.i_if_req && bus.i_ls_req) begin
            grant_if = tie_to_if;
            grant_ls = !tie_to_if;
          end else begin
            grant_if = bus.i_if_req;
            grant_ls = bus.i_ls_req;
          end
          if (grant_if || grant_ls) state_d = ISSUE;
        end
      end
      ISSUE:   if (bus.i_mem_ready) state_d = WAIT;
      WAIT:    if (bus.i_mem_valid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      mask_q     <= 4'd0;
      wen_q      <= 1'b0;
      owner_ls_q <= 1'b0;
      if_rdata_q <= 32'd0;
      ls_rdata_q <= 32'd0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_if) begin
        addr_q     <= bus.i_if_addr & 32'hFFFF_FFFC;
        wdata_q    <= 32'd0;
        mask_q     <= 4'b1111;
        wen_q      <= 1'b0;
        owner_ls_q <= 1'b0;
      end else if (grant_ls) begin
        addr_q     <= bus.i_ls_addr & 32'hFFFF_FFFC;
        wdata_q    <= bus.i_ls_wdata;
        mask_q     <= bus.i_ls_mask;
        wen_q      <= bus.i_ls_wen;
        owner_ls_q <= 1'b1;
      end
      if ((state_q == WAIT) && bus.i_mem_valid) begin
        if (owner_ls_q) ls_rdata_q <= bus.i_mem_rdata;
        else            if_rdata_q <= bus.i_mem_rdata;
      end
      if_valid_q <= (state_q == WAIT) && bus.i_mem_valid && !owner_ls_q;
      ls_valid_q <= (state_q == WAIT) && bus.i_mem_valid &&  owner_ls_q;
    end
  end

  assign bus.o_if_ready  = grant_if;
  assign bus.o_ls_ready  = grant_ls;
  assign bus.o_if_valid  = if_valid_q;
  assign bus.o_ls_valid  = ls_valid_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_ls_rdata  = ls_rdata_q;
  assign bus.o_mem_req   = (state_q == ISSUE);
  assign bus.o_mem_wen   = wen_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_mask  = mask_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int LIMIT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  logic [1:0] dbg_state;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- requester / memory stimulus state ----------------
  logic        p_if, p_ls, f_ls_wen;
  logic [31:0] f_if_addr, f_ls_addr, f_ls_wdata;
  logic [3:0]  f_ls_mask;
  bit          rand_req = 0, keep_both = 0, rand_mem = 0, use_fixed = 0;
  logic [31:0] fixed_rdata = 32'd0;
  int          rdy_delay = 0, vld_delay = 0, rdy_cnt = 0, vld_cnt = 0;
  bit          in_wait = 0;

  // ---------------- behavioural model ----------------
  bit          m_busy, m_issued, m_resp, m_last_ls, m_owner_ls, m_wen;
  int          m_starve;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_mask;
  logic        dut_grants[$];

  // values seen during the previous cycle, consumed at the following edge
  logic        s_rst, s_if_req, s_ls_req, s_if_ready, s_ls_ready;
  logic        s_mem_req, s_mem_ready, s_mem_valid, s_ls_wen;
  logic [31:0] s_if_addr, s_ls_addr, s_ls_wdata, s_mem_rdata;
  logic [3:0]  s_ls_mask;

  // event counters and first-occurrence markers for the directed checks
  int          if_ready_cnt = 0, ls_ready_cnt = 0, if_valid_cnt = 0, ls_valid_cnt = 0, mem_req_cyc = 0;
  int          t_rdy, t_req, t_vld;
  logic [31:0] req_addr, vld_data;
  logic        req_wen;
  logic [3:0]  req_mask;

  function automatic logic [1:0] pick(input logic rq_if, input logic rq_ls); // {fetch, data}
    if (rq_if && rq_ls) begin
`ifdef MEM_ARB_RR_EN
      return m_last_ls ? 2'b10 : 2'b01;
`else
      return (m_starve == LIMIT) ? 2'b10 : 2'b01;
`endif
    end
    return {rq_if, rq_ls};
  endfunction

  task automatic model_edge();
    logic [1:0] w;
    if (s_rst) begin
      m_busy = 0; m_issued = 0; m_resp = 0; m_starve = 0; m_last_ls = 1;
    end else if (!m_busy) begin
      w = pick(s_if_req, s_ls_req);
      if (w != 2'b00) begin
        m_busy = 1; m_issued = 0; m_resp = 0;
        m_owner_ls = w[0];
        m_last_ls  = w[0];
        if (w[1]) begin
          m_addr = {s_if_addr[31:2], 2'b00}; m_wen = 0; m_mask = 4'hF; m_wdata = 32'd0;
          m_starve = 0;
        end else begin
          m_addr = {s_ls_addr[31:2], 2'b00}; m_wen = s_ls_wen; m_mask = s_ls_mask; m_wdata = s_ls_wdata;
          if (s_if_req && m_starve < LIMIT) m_starve++;
        end
      end
    end else if (!m_issued) begin
      if (s_mem_ready) m_issued = 1;
    end else if (!m_resp) begin
      if (s_mem_valid) begin m_resp = 1; m_rdata = s_mem_rdata; end
    end else begin
      m_busy = 0; m_resp = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_if();
    p_if = 1; f_if_addr = $urandom;
  endtask

  task automatic new_ls();
    p_ls = 1; f_ls_wen = 1'($urandom_range(0, 1)); f_ls_addr = $urandom;
    f_ls_wdata = $urandom; f_ls_mask = 4'($urandom_range(1, 15));
  endtask

  task automatic stim_edge();
    if (!s_rst) begin
      if (s_if_ready) begin p_if = 0; dut_grants.push_back(1'b0); end
      if (s_ls_ready) begin p_ls = 0; dut_grants.push_back(1'b1); end
    end
    if (in_wait) begin
      if (s_mem_valid) in_wait = 0;
      else vld_cnt++;
    end
    if (s_mem_req && s_mem_ready) begin
      in_wait = 1; vld_cnt = 0; rdy_cnt = 0;
      if (rand_mem) begin rdy_delay = $urandom_range(0, 3); vld_delay = $urandom_range(0, 3); end
    end else if (s_mem_req) begin
      rdy_cnt++;
    end
    if (keep_both) begin
      if (!p_if) new_if();
      if (!p_ls) new_ls();
    end else if (rand_req) begin
      if (!p_if && $urandom_range(0, 2) == 0) new_if();
      if (!p_ls && $urandom_range(0, 2) == 0) new_ls();
    end
  endtask

  task automatic drive_req();
    bus.i_if_req = p_if;   bus.i_if_addr = f_if_addr;
    bus.i_ls_req = p_ls;   bus.i_ls_wen = f_ls_wen; bus.i_ls_addr = f_ls_addr;
    bus.i_ls_wdata = f_ls_wdata; bus.i_ls_mask = f_ls_mask;
  endtask

  task automatic drive_mem();
    bus.i_mem_ready = bus.o_mem_req && (rdy_cnt >= rdy_delay);
    bus.i_mem_valid = (in_wait && vld_cnt >= vld_delay) ||
                      (rand_mem && !in_wait && $urandom_range(0, 3) == 0);
    bus.i_mem_rdata = use_fixed ? fixed_rdata : $urandom;
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic compare();
    logic [1:0] w;
    logic exp_req, exp_ifv, exp_lsv;
    w = (rst || m_busy) ? 2'b00 : pick(bus.i_if_req, bus.i_ls_req);
    chk("if_ready", 32'(bus.o_if_ready), 32'(w[1]));
    chk("ls_ready", 32'(bus.o_ls_ready), 32'(w[0]));
    exp_req = m_busy && !m_issued;
    chk("mem_req", 32'(bus.o_mem_req), 32'(exp_req));
    if (exp_req) begin
      chk("mem_addr", bus.o_mem_addr, m_addr);
      chk("mem_wen",  32'(bus.o_mem_wen), 32'(m_wen));
      chk("mem_mask", 32'(bus.o_mem_mask), 32'(m_mask));
      if (m_wen) chk("mem_wdata", bus.o_mem_wdata, m_wdata);
    end
    exp_ifv = m_busy && m_resp && !m_owner_ls;
    exp_lsv = m_busy && m_resp &&  m_owner_ls;
    chk("if_valid", 32'(bus.o_if_valid), 32'(exp_ifv));
    chk("ls_valid", 32'(bus.o_ls_valid), 32'(exp_lsv));
    if (exp_ifv) chk("if_rdata", bus.o_if_rdata, m_rdata);
    if (exp_lsv && !m_wen) chk("ls_rdata", bus.o_ls_rdata, m_rdata);

    if (bus.o_if_ready) if_ready_cnt++;
    if (bus.o_ls_ready) ls_ready_cnt++;
    if (bus.o_if_valid) if_valid_cnt++;
    if (bus.o_ls_valid) ls_valid_cnt++;
    if (bus.o_mem_req)  mem_req_cyc++;
    if (t_rdy < 0 && (bus.o_if_ready || bus.o_ls_ready)) t_rdy = cyc;
    if (t_req < 0 && bus.o_mem_req) begin
      t_req = cyc; req_addr = bus.o_mem_addr; req_wen = bus.o_mem_wen; req_mask = bus.o_mem_mask;
    end
    if (t_vld < 0 && (bus.o_if_valid || bus.o_ls_valid)) begin
      t_vld = cyc; vld_data = bus.o_if_valid ? bus.o_if_rdata : bus.o_ls_rdata;
    end

    s_rst = rst; s_if_req = bus.i_if_req; s_ls_req = bus.i_ls_req;
    s_if_ready = bus.o_if_ready; s_ls_ready = bus.o_ls_ready;
    s_mem_req = bus.o_mem_req; s_mem_ready = bus.i_mem_ready;
    s_mem_valid = bus.i_mem_valid; s_mem_rdata = bus.i_mem_rdata;
    s_if_addr = bus.i_if_addr; s_ls_addr = bus.i_ls_addr; s_ls_wdata = bus.i_ls_wdata;
    s_ls_mask = bus.i_ls_mask; s_ls_wen = bus.i_ls_wen;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    cyc++;
    model_edge();
    stim_edge();
    drive_req(); #1;
    drive_mem(); #1;
    compare();
  endtask

  task automatic clear_marks();
    t_rdy = -1; t_req = -1; t_vld = -1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (m_busy || p_if || p_ls); i++) cycle();
    chk("drain_done", 32'(m_busy || p_if || p_ls), 32'd0);
    cycle(); cycle();
  endtask

  task automatic check_reset_values();
    chk("rst_if_ready", 32'(bus.o_if_ready), 32'd0);
    chk("rst_ls_ready", 32'(bus.o_ls_ready), 32'd0);
    chk("rst_if_valid", 32'(bus.o_if_valid), 32'd0);
    chk("rst_ls_valid", 32'(bus.o_ls_valid), 32'd0);
    chk("rst_mem_req",  32'(bus.o_mem_req),  32'd0);
    chk("rst_mem_wen",  32'(bus.o_mem_wen),  32'd0);
    chk("rst_mem_addr", bus.o_mem_addr,  32'd0);
    chk("rst_mem_wdata", bus.o_mem_wdata, 32'd0);
    chk("rst_mem_mask", 32'(bus.o_mem_mask), 32'd0);
    chk("rst_if_rdata", bus.o_if_rdata, 32'd0);
    chk("rst_ls_rdata", bus.o_ls_rdata, 32'd0);
    chk("rst_state_idle", 32'(dbg_state), 32'd0);
  endtask

  int v0, r0, m0;
  logic exp_order[6];

  initial begin
    p_if = 0; p_ls = 0; f_ls_wen = 0; f_if_addr = 0; f_ls_addr = 0; f_ls_wdata = 0; f_ls_mask = 0;
    m_busy = 0; m_issued = 0; m_resp = 0; m_starve = 0; m_last_ls = 1;
    m_owner_ls = 0; m_wen = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_mask = 0;
    s_rst = 1; s_if_req = 0; s_ls_req = 0; s_if_ready = 0; s_ls_ready = 0; s_mem_req = 0;
    s_mem_ready = 0; s_mem_valid = 0; s_ls_wen = 0; s_if_addr = 0; s_ls_addr = 0;
    s_ls_wdata = 0; s_mem_rdata = 0; s_ls_mask = 0;
    clear_marks();
    drive_req();
    bus.i_mem_ready = 0; bus.i_mem_valid = 0; bus.i_mem_rdata = 0;

    rst = 1;
    cycle(); cycle();
    check_reset_values();
    rst = 0;
    cycle(); cycle();

    // single fetch, immediate memory
    use_fixed = 1; fixed_rdata = 32'h00A00093;
    clear_marks();
    p_if = 1; f_if_addr = 32'h0000_0010;
    v0 = if_valid_cnt;
    for (int i = 0; i < 10 && if_valid_cnt == v0; i++) cycle();
    chk("fetch_req_latency", 32'(t_req - t_rdy), 32'd1);
    chk("fetch_vld_latency", 32'(t_vld - t_rdy), 32'd3);
    chk("fetch_mem_addr", req_addr, 32'h0000_0010);
    chk("fetch_mem_mask", 32'(req_mask), 32'hF);
    chk("fetch_rdata", vld_data, 32'h00A00093);
    drain();

    // byte store
    clear_marks();
    p_ls = 1; f_ls_wen = 1; f_ls_addr = 32'h0000_2003; f_ls_wdata = 32'hAB00_0000; f_ls_mask = 4'b1000;
    v0 = ls_valid_cnt;
    for (int i = 0; i < 10 && ls_valid_cnt == v0; i++) cycle();
    drain();
    chk("store_mem_addr", req_addr, 32'h0000_2000);
    chk("store_mem_wen", 32'(req_wen), 32'd1);
    chk("store_mem_mask", 32'(req_mask), 32'h8);
    chk("store_valid_once", 32'(ls_valid_cnt - v0), 32'd1);

    // memory stall; a fetch waiting behind it must not be accepted early
    use_fixed = 0; rdy_delay = 5; vld_delay = 3;
    p_ls = 1; f_ls_wen = 0; f_ls_addr = 32'h0000_0040; f_ls_mask = 4'hF;
    v0 = ls_valid_cnt; r0 = if_ready_cnt + ls_ready_cnt; m0 = mem_req_cyc;
    cycle();
    p_if = 1; f_if_addr = 32'h0000_0044;
    for (int i = 0; i < 30 && ls_valid_cnt == v0; i++) cycle();
    chk("stall_mem_req_cycles", 32'(mem_req_cyc - m0), 32'd6);
    chk("stall_single_accept", 32'(if_ready_cnt + ls_ready_cnt - r0), 32'd1);
    rdy_delay = 0; vld_delay = 0;
    drain();
    chk("stall_valid_once", 32'(ls_valid_cnt - v0), 32'd1);

    // contention from a fresh reset
    rst = 1; cycle(); cycle(); rst = 0;
    dut_grants.delete();
    keep_both = 1;
    for (int i = 0; i < 60 && dut_grants.size() < 6; i++) cycle();
    keep_both = 0;
    drain();
`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
    chk("contention_count_ge6", 32'(dut_grants.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < dut_grants.size(); i++)
      chk($sformatf("grant_order_%0d", i), 32'(dut_grants[i]), 32'(exp_order[i]));

    // reset while waiting for memory; the late response must be dropped
    vld_delay = 6;
    p_if = 1; f_if_addr = 32'h0000_0080;
    for (int i = 0; i < 10 && !in_wait; i++) cycle();
    cycle(); cycle();
    v0 = if_valid_cnt + ls_valid_cnt;
    rst = 1; cycle(); cycle();
    check_reset_values();
    rst = 0;
    for (int i = 0; i < 10; i++) cycle();
    chk("late_valid_dropped", 32'(if_valid_cnt + ls_valid_cnt - v0), 32'd0);
    chk("memory_responded", 32'(in_wait), 32'd0);
    vld_delay = 0;
    clear_marks();
    p_if = 1; f_if_addr = 32'h0000_0084;
    v0 = if_valid_cnt;
    for (int i = 0; i < 10 && if_valid_cnt == v0; i++) cycle();
    chk("post_reset_fetch", 32'(if_valid_cnt - v0), 32'd1);
    chk("post_reset_latency", 32'(t_vld - t_rdy), 32'd3);
    drain();

    // random traffic with random stalls and stray memory valids
    rand_req = 1; rand_mem = 1;
    for (int i = 0; i < 2000; i++) cycle();
    rand_req = 0; rand_mem = 0; rdy_delay = 0; vld_delay = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
